// File: rtl/sha256_block_seq.sv
// SHA-256 block sequencer: drives the compression datapath strobes for one or more 512-bit blocks.
// Optional synchronous abort input is enabled by defining SHA256_SEQ_ABORT_EN.
module sha256_block_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_last,
    output logic       dp_hash_init,
    output logic       dp_blk_start,
    output logic       dp_w_sel,
    output logic       dp_round_en,
    output logic [5:0] dp_round_idx,
    output logic       dp_ff_add,
    output logic [2:0] dp_out_sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
`ifdef SHA256_SEQ_ABORT_EN
   ,input  logic       abort
`endif
);

    typedef enum logic [2:0] {IDLE, INIT, LOAD, ROUND, FINAL, OUT} state_t;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_t;
    logic [2:0] r_out_idx;
    logic       r_last;
    logic       r_new_msg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_t       <= '0;
            r_out_idx <= '0;
            r_last    <= 1'b0;
            r_new_msg <= 1'b0;
        end else
`ifdef SHA256_SEQ_ABORT_EN
        if (abort) begin
            r_state   <= IDLE;
            r_t       <= '0;
            r_out_idx <= '0;
            r_last    <= 1'b0;
            r_new_msg <= 1'b0;
        end else
`endif
        begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (in_valid) r_new_msg <= 1'b1;
                INIT: begin
                    r_t       <= '0;
                    r_new_msg <= 1'b0;
                end
                LOAD: if (in_valid) begin
                    r_t <= r_t + 6'd1;
                    if (r_t == 6'd15) r_last <= in_last;
                end
                // t parks at 63 so the index never wraps inside a block
                ROUND: if (r_t != 6'd63) r_t <= r_t + 6'd1;
                FINAL: r_out_idx <= '0;
                OUT: if (out_ready) begin
                    r_out_idx <= r_out_idx + 3'd1;
                    if (r_out_idx == 3'd7) r_last <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next       = r_state;
        in_ready     = 1'b0;
        dp_hash_init = 1'b0;
        dp_blk_start = 1'b0;
        dp_w_sel     = 1'b0;
        dp_round_en  = 1'b0;
        dp_round_idx = '0;
        dp_ff_add    = 1'b0;
        dp_out_sel   = '0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: if (in_valid) w_next = INIT;
            INIT: begin
                dp_blk_start = 1'b1;
                dp_hash_init = r_new_msg;
                w_next       = LOAD;
            end
            LOAD: begin
                in_ready     = 1'b1;
                dp_round_idx = r_t;
                if (in_valid) begin
                    dp_round_en = 1'b1;
                    if (r_t == 6'd15) w_next = ROUND;
                end
            end
            ROUND: begin
                dp_round_en  = 1'b1;
                dp_w_sel     = 1'b1;
                dp_round_idx = r_t;
                if (r_t == 6'd63) w_next = FINAL;
            end
            FINAL: begin
                dp_ff_add = 1'b1;
                w_next    = r_last ? OUT : INIT;
            end
            OUT: begin
                out_valid  = 1'b1;
                dp_out_sel = r_out_idx;
                out_last   = (r_out_idx == 3'd7);
                if (out_ready && r_out_idx == 3'd7) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
`ifdef SHA256_SEQ_ABORT_EN
        // abort silences every strobe and handshake in the cycle it is asserted
        if (abort) begin
            w_next       = IDLE;
            in_ready     = 1'b0;
            dp_hash_init = 1'b0;
            dp_blk_start = 1'b0;
            dp_w_sel     = 1'b0;
            dp_round_en  = 1'b0;
            dp_round_idx = '0;
            dp_ff_add    = 1'b0;
            dp_out_sel   = '0;
            out_valid    = 1'b0;
            out_last     = 1'b0;
        end
`endif
    end

endmodule
